// File: rtl/core_bus_pkg.sv
// core_bus_pkg -- shared definitions for the core bus arbiter.
//   state_e           : arbiter FSM states (idle, bus cycle, response pulse).
//   ARB_FIXED/ARB_RR  : arbitration mode encodings.
//   TIMEOUT_RDATA_BIT : fill bit for read data reported on a timed-out transfer.
//   idx_width()       : width of a channel index, at least one bit.
package core_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  localparam logic TIMEOUT_RDATA_BIT = 1'b0;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- combinational winner select.
//   req_i   : per-channel request levels.
//   ptr_i   : first channel to consider in round-robin mode.
//   mode_i  : ARB_FIXED (search from channel 0) or ARB_RR (search from ptr_i).
//   idx_o   : index of the winning channel (0 when nothing requests).
//   valid_o : at least one channel requests.
module rr_arbiter
  import core_bus_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int IW     = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  input  logic              mode_i,
  output logic [IW-1:0]     idx_o,
  output logic              valid_o
);

  always_comb begin
    int start;
    int k;
    logic found;
    idx_o   = '0;
    found   = 1'b0;
    start   = (mode_i == ARB_RR) ? int'(ptr_i) : 0;
    k       = 0;
    // Walk the channels once, wrapping at NUM_CH; the first requester wins.
    for (int i = 0; i < NUM_CH; i++) begin
      k = (start + i) % NUM_CH;
      if (!found && req_i[k]) begin
        found = 1'b1;
        idx_o = IW'(k);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter -- shares one Wishbone classic master among NUM_CH channels.
//   clk, rst_n           : clock, asynchronous active-low reset.
//   ch_req_i/we/addr/wdata/sel : per-channel request level and packed fields.
//   ch_done_o, ch_err_o  : one-cycle completion pulse and timeout flag.
//   ch_rdata_o           : read data of the last completed read (0 on timeout).
//   wb_*                 : Wishbone classic master port.
// A granted request is latched, so the bus sees stable fields even if the
// channel drops its request mid-transfer.
module core_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter int NUM_CH         = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ARB_MODE       = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CH-1:0]                ch_req_i,
  input  logic [NUM_CH-1:0]                ch_we_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]     ch_addr_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     ch_wdata_i,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0]   ch_sel_i,
  output logic [NUM_CH-1:0]                ch_done_o,
  output logic [NUM_CH-1:0]                ch_err_o,
  output logic [DATA_WIDTH-1:0]            ch_rdata_o,
  output logic                             wb_cyc_o,
  output logic                             wb_stb_o,
  output logic                             wb_we_o,
  output logic [ADDR_WIDTH-1:0]            wb_addr_o,
  output logic [DATA_WIDTH-1:0]            wb_data_o,
  output logic [DATA_WIDTH/8-1:0]          wb_sel_o,
  input  logic [DATA_WIDTH-1:0]            wb_data_i,
  input  logic                             wb_ack_i
);

  localparam int   IW       = idx_width(NUM_CH);
  localparam int   SW       = DATA_WIDTH / 8;
  localparam int   CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic MODE_BIT = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

  state_e                state_q, state_d;
  logic [IW-1:0]         win_q, win_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [IW-1:0]         arb_idx;
  logic                  arb_valid;
  logic [CW-1:0]         cnt_inc;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_arb (
    .req_i   (ch_req_i),
    .ptr_i   (ptr_q),
    .mode_i  (MODE_BIT),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          win_d   = arb_idx;
          we_d    = ch_we_i[arb_idx];
          addr_d  = ch_addr_i[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = ch_wdata_i[arb_idx*DATA_WIDTH +: DATA_WIDTH];
          sel_d   = ch_sel_i[arb_idx*SW +: SW];
          cnt_d   = '0;
          err_d   = 1'b0;
          // Pointer names the channel after the winner, wrapping at NUM_CH.
          ptr_d   = (int'(arb_idx) == NUM_CH - 1) ? '0 : arb_idx + IW'(1);
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // An ack in the terminal-count cycle still completes normally.
        if (wb_ack_i) begin
          if (!we_q) begin
            rdata_d = wb_data_i;
          end
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
            err_d   = 1'b1;
            rdata_d = {DATA_WIDTH{TIMEOUT_RDATA_BIT}};
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus controls come straight from state flops, so reset clears them
  // without waiting for a clock edge.
  assign wb_cyc_o   = (state_q == ST_BUS);
  assign wb_stb_o   = (state_q == ST_BUS);
  assign wb_we_o    = (state_q == ST_BUS) && we_q;
  assign wb_addr_o  = addr_q;
  assign wb_data_o  = wdata_q;
  assign wb_sel_o   = sel_q;
  assign ch_rdata_o = rdata_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_done
    assign ch_done_o[gi] = (state_q == ST_RESP) && (win_q == IW'(gi));
    assign ch_err_o[gi]  = ch_done_o[gi] && err_q;
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
module tb_core_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  ch_req, ch_we;
  logic [95:0] ch_addr, ch_wdata;
  logic [11:0] ch_sel;
  logic [2:0]  ch_done, ch_err;
  logic [31:0] ch_rdata;
  logic        cyc, stb, we;
  logic [31:0] waddr, wdat, slave_rdata;
  logic [3:0]  wsel;
  logic        ack;

  // Fixed-priority instance sharing the channel fields, immediate-ack slave.
  logic        fp_en;
  logic [2:0]  fp_req, fp_done, fp_err;
  logic [31:0] fp_rdata, fp_addr, fp_wdat;
  logic        fp_cyc, fp_stb, fp_we;
  logic [3:0]  fp_sel;
  int          fp_cnt;

  int   ack_delay;
  logic stray_ack;
  int   bus_cnt;
  int   checks = 0;
  int   failures = 0;

  assign ack    = stray_ack | (cyc && (ack_delay >= 0) && (bus_cnt == ack_delay));
  assign fp_req = fp_en ? ch_req : 3'b000;

  always @(posedge clk) bus_cnt <= cyc ? bus_cnt + 1 : 0;

  core_bus_arbiter #(.NUM_CH(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .ch_req_i(ch_req), .ch_we_i(ch_we), .ch_addr_i(ch_addr),
    .ch_wdata_i(ch_wdata), .ch_sel_i(ch_sel), .ch_done_o(ch_done), .ch_err_o(ch_err),
    .ch_rdata_o(ch_rdata), .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_addr_o(waddr),
    .wb_data_o(wdat), .wb_sel_o(wsel), .wb_data_i(slave_rdata), .wb_ack_i(ack));

  core_bus_arbiter #(.NUM_CH(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0), .TIMEOUT_CYCLES(4)) dut_fp (
    .clk(clk), .rst_n(rst_n), .ch_req_i(fp_req), .ch_we_i(ch_we), .ch_addr_i(ch_addr),
    .ch_wdata_i(ch_wdata), .ch_sel_i(ch_sel), .ch_done_o(fp_done), .ch_err_o(fp_err),
    .ch_rdata_o(fp_rdata), .wb_cyc_o(fp_cyc), .wb_stb_o(fp_stb), .wb_we_o(fp_we), .wb_addr_o(fp_addr),
    .wb_data_o(fp_wdat), .wb_sel_o(fp_sel), .wb_data_i(slave_rdata), .wb_ack_i(fp_cyc));

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; logic [3:0] sel; } bus_exp_t;
  typedef struct { logic [2:0] done; logic [2:0] err; logic [31:0] rdata; int len; } done_exp_t;
  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: bus fields on cyc rise and stability while high; completion on done.
  logic     prev_cyc = 1'b0;
  int       run_len = 0;
  int       last_len = 0;
  bus_exp_t cur;
  always @(negedge clk) begin
    done_exp_t d;
    if (cyc) begin
      if (!prev_cyc) begin
        run_len = 1;
        if (bus_q.size() == 0) begin
          chk("unexpected_cyc", 32'(cyc), 32'd0);
          cur = '{we, waddr, wdat, wsel};
        end else begin
          cur = bus_q.pop_front();
          chk("bus_addr", waddr, cur.addr);
          chk("bus_we", 32'(we), 32'(cur.we));
          chk("bus_wdata", wdat, cur.data);
          chk("bus_sel", 32'(wsel), 32'(cur.sel));
        end
      end else begin
        run_len++;
        chk("bus_stable", {we, waddr[30:0]} ^ wdat ^ 32'(wsel), {cur.we, cur.addr[30:0]} ^ cur.data ^ 32'(cur.sel));
      end
      chk("stb_eq_cyc", 32'(stb), 32'd1);
    end else if (prev_cyc) begin
      last_len = run_len;
    end
    if (ch_done != 3'b000) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 32'(ch_done), 32'd0);
      end else begin
        d = done_q.pop_front();
        chk("done_vec", 32'(ch_done), 32'(d.done));
        chk("err_vec", 32'(ch_err), 32'(d.err));
        chk("rdata", ch_rdata, d.rdata);
        chk("bus_len", 32'(last_len), 32'(d.len));
        chk("done_latency", 32'(prev_cyc), 32'd1);
      end
    end
    prev_cyc = cyc;
  end

  always @(negedge clk) begin
    if (fp_en && fp_done != 3'b000) begin
      fp_cnt++;
      chk("fp_grant", 32'(fp_done), 32'd1);
    end
  end

  task automatic set_ch(input int ch, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    ch_we[ch]             = w;
    ch_addr[ch*32 +: 32]  = a;
    ch_wdata[ch*32 +: 32] = d;
    ch_sel[ch*4 +: 4]     = s;
  endtask

  task automatic wait_done(input int n, input string tag);
    int got = 0;
    for (int i = 0; i < 300 && got < n; i++) begin
      @(negedge clk);
      if (ch_done != 3'b000) got++;
    end
    chk(tag, 32'(got), 32'(n));
  endtask

  task automatic xfer(input int ch, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int dly, input logic [31:0] exp_rd,
                      input logic exp_err, input int exp_len);
    logic [2:0] dv;
    dv = 3'(1 << ch);
    set_ch(ch, w, a, d, s);
    ack_delay = dly;
    bus_q.push_back('{w, a, d, s});
    done_q.push_back('{dv, exp_err ? dv : 3'b000, exp_rd, exp_len});
    ch_req[ch] = 1'b1;
    wait_done(1, "xfer_done_seen");
    ch_req[ch] = 1'b0;
  endtask

  initial begin
    ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0; ch_sel = '0;
    ack_delay = -1; stray_ack = 1'b0; slave_rdata = '0; fp_en = 1'b0; fp_cnt = 0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", waddr, 32'd0);
    chk("rst_wdata", wdat, 32'd0);
    chk("rst_sel", 32'(wsel), 32'd0);
    chk("rst_done", 32'(ch_done), 32'd0);
    chk("rst_err", 32'(ch_err), 32'd0);
    chk("rst_rdata", ch_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read, ack on third bus cycle.
    slave_rdata = 32'hCAFEBABE;
    xfer(1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 2, 32'hCAFEBABE, 1'b0, 3);
    // Write leaves read data untouched.
    xfer(2, 1'b1, 32'h0000_0080, 32'h1234_5678, 4'b0011, 1, 32'hCAFEBABE, 1'b0, 2);

    // Ack while idle must do nothing.
    stray_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_cyc", 32'(cyc), 32'd0);
      chk("stray_done", 32'(ch_done), 32'd0);
    end
    stray_ack = 1'b0;

    // Round-robin with all three requesting, immediate ack.
    set_ch(0, 1'b0, 32'h0000_1000, 32'h1111_1111, 4'hF);
    set_ch(1, 1'b0, 32'h0000_1010, 32'h2222_2222, 4'h3);
    set_ch(2, 1'b0, 32'h0000_1020, 32'h3333_3333, 4'hC);
    slave_rdata = 32'h0BAD_F00D;
    ack_delay = 0;
    for (int t = 0; t < 6; t++) begin
      case (t % 3)
        0: bus_q.push_back('{1'b0, 32'h0000_1000, 32'h1111_1111, 4'hF});
        1: bus_q.push_back('{1'b0, 32'h0000_1010, 32'h2222_2222, 4'h3});
        default: bus_q.push_back('{1'b0, 32'h0000_1020, 32'h3333_3333, 4'hC});
      endcase
      done_q.push_back('{3'(1 << (t % 3)), 3'b000, 32'h0BAD_F00D, 1});
    end
    fp_cnt = 0;
    fp_en = 1'b1;
    ch_req = 3'b111;
    wait_done(6, "rr_done_count");
    ch_req = 3'b000;
    @(negedge clk);
    fp_en = 1'b0;
    chk("fp_count", 32'(fp_cnt), 32'd6);

    // Timeout: no ack, four bus cycles, error and zero data.
    xfer(0, 1'b0, 32'h0000_0200, 32'hDEAD_0000, 4'hF, -1, 32'h0, 1'b1, 4);
    // Ack on the terminal-count cycle wins.
    slave_rdata = 32'h600D_CAFE;
    xfer(2, 1'b0, 32'h0000_0240, 32'h0, 4'hF, 3, 32'h600D_CAFE, 1'b0, 4);

    // Reset in the middle of a transfer (channel 1 granted, pointer moves to 2).
    set_ch(1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
    ack_delay = -1;
    bus_q.push_back('{1'b0, 32'h0000_0300, 32'h0, 4'hF});
    ch_req = 3'b010;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cyc) break;
    end
    chk("mr_cyc_up", 32'(cyc), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_cyc_async", 32'(cyc), 32'd0);
    chk("mr_stb_async", 32'(stb), 32'd0);
    ch_req = 3'b000;
    repeat (3) begin
      @(negedge clk);
      chk("mr_no_done", 32'(ch_done), 32'd0);
      chk("mr_rdata", ch_rdata, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    set_ch(0, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
    set_ch(2, 1'b0, 32'h0000_0420, 32'h0, 4'hF);
    slave_rdata = 32'h1234_ABCD;
    ack_delay = 0;
    bus_q.push_back('{1'b0, 32'h0000_0400, 32'h0, 4'hF});
    done_q.push_back('{3'b001, 3'b000, 32'h1234_ABCD, 1});
    ch_req = 3'b111;
    wait_done(1, "post_reset_done");
    ch_req = 3'b000;
    repeat (4) @(negedge clk);

    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_CH, 3, request channels (1..4): instruction fetch, data read, data write, spare.
  ADDR_WIDTH, 32, address width.
  DATA_WIDTH, 32, data width (multiple of 8).
  ARB_MODE, 1, 0 = fixed priority, 1 = round-robin.
  TIMEOUT_CYCLES, 255, maximum wait for wb_ack_i (1..65535).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all logic on its rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  ch_req_i  in  NUM_CH  per-channel request level.
  ch_we_i  in  NUM_CH  per-channel write flag.
  ch_addr_i  in  NUM_CH*ADDR_WIDTH  packed addresses; channel k at slice k.
  ch_wdata_i  in  NUM_CH*DATA_WIDTH  packed write data.
  ch_sel_i  in  NUM_CH*DATA_WIDTH/8  packed byte enables.
  ch_done_o  out  NUM_CH  one-cycle completion pulse.
  ch_err_o  out  NUM_CH  valid with ch_done_o; 1 = timeout.
  ch_rdata_o  out  DATA_WIDTH  read data of the completed transfer, held until the next completion.
  wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone classic master controls.
  wb_addr_o  out  ADDR_WIDTH  bus address.
  wb_data_o  out  DATA_WIDTH  bus write data.
  wb_sel_o  out  DATA_WIDTH/8  bus byte enables.
  wb_data_i  in  DATA_WIDTH  bus read data.
  wb_ack_i  in  1  bus acknowledge.
REQ-003 Reset SHALL be asynchronous and active-low on rst_n, with one clock, clk.

Function
REQ-004 FSM states SHALL be IDLE, BUS and RESP.
REQ-005 IDLE: if any ch_req_i bit is set, the FSM SHALL latch the winner index, we, addr, wdata and sel into registers and enter BUS next cycle; otherwise it stays in IDLE.
REQ-006 BUS: wb_cyc_o and wb_stb_o SHALL be 1 and all wb_* outputs driven from the latched registers, stable for the whole state.
REQ-007 BUS with wb_ack_i=1: the FSM SHALL capture wb_data_i into ch_rdata_o (reads only; writes leave it unchanged), drop cyc/stb next cycle and enter RESP.
REQ-008 RESP: ch_done_o[winner] SHALL be 1 for exactly this cycle, and the FSM returns to IDLE.
REQ-009 Latency: request sampled in IDLE at cycle 0 gives cyc/stb at cycle 1; ack at cycle k gives done at cycle k+1; earliest next cyc is at cycle k+3.
REQ-010 Timeout: a counter SHALL clear on BUS entry and increment each BUS cycle without ack. When it reaches TIMEOUT_CYCLES, the FSM enters RESP with ch_err_o[winner]=1 and ch_rdata_o=0.
REQ-011 Ack and timeout in the same cycle: ack wins and err=0.
REQ-012 wb_ack_i outside BUS SHALL be ignored.
REQ-013 ARB_MODE=0: the lowest-index requesting channel SHALL win.
REQ-014 ARB_MODE=1: search SHALL start at (last winner+1) mod NUM_CH; the pointer updates only on grant and is 0 after reset.
REQ-015 A channel SHALL hold its request fields stable until its ch_done_o. A request still high in the cycle after done is treated as a new request.
REQ-016 Deassertion of ch_req_i during BUS SHALL NOT abort the transfer.
REQ-017 NUM_CH=1 SHALL degenerate to a pass-through with identical timing.

Reset
REQ-018 While rst_n=0: state IDLE; wb_cyc_o, wb_stb_o, wb_we_o =0; wb_addr_o, wb_data_o, wb_sel_o =0; ch_done_o, ch_err_o, ch_rdata_o =0; timeout counter =0; round-robin pointer =0.
REQ-019 Reset asserted mid-transfer SHALL drop cyc/stb immediately, with no done pulse.

Structure
REQ-020 Package core_bus_pkg SHALL hold the state enum, ARB_FIXED=0, ARB_RR=1, and the timeout error read value.
REQ-021 Sub-module rr_arbiter SHALL be the combinational winner-select taking (req, pointer, mode) and returning the index and a valid flag. The pointer register lives in core_bus_arbiter.
REQ-022 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-023 Single read: ch1 req, addr 0x100, slave acks after 2 cycles with 0xCAFEBABE -> cyc/stb high for 3 cycles, ch_done_o=3'b010 for one cycle, ch_rdata_o=0xCAFEBABE, err=0.
REQ-024 Write: ch2 we=1, addr 0x80, wdata 0x12345678, sel 4'b0011 -> wb outputs match for the whole transfer, done on ch2, ch_rdata_o unchanged.
REQ-025 Round-robin: ch0, ch1 and ch2 held continuously for 6 transfers with immediate ack -> grant order 0,1,2,0,1,2. With ARB_MODE=0 the order is 0,0,0...
REQ-026 Timeout with TIMEOUT_CYCLES=4 and no ack -> cyc drops after 4 BUS cycles, done and err on the winner, ch_rdata_o=0.
REQ-027 Ack coinciding with the timeout terminal count -> err=0 and data captured.
REQ-028 rst_n pulsed low during BUS -> cyc/stb=0 asynchronously, no done pulse, first grant after reset goes to ch0.
